// File: rtl/traffic_generator_gmii_pkg.sv
// Shared types and constants for the GMII traffic generator frame sequencer.
// CRC helpers are used only when TRAFFIC_GENERATOR_GMII_FCS_EN is defined.
package traffic_generator_gmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_FCS,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 8;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  // Remainder left after running the CRC over a frame together with its own FCS.
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first (reflected) update: one byte folded into the running register.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    logic [31:0] poly_r;
    poly_r = bit_reverse32(CRC32_POLY);
    c = crc ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/traffic_generator_gmii_crc32.sv
// Byte-per-cycle IEEE 802.3 CRC-32; init loads all ones, en folds in one byte.
// Instantiated by the scheduler only when TRAFFIC_GENERATOR_GMII_FCS_EN is defined.
module traffic_generator_gmii_crc32
  import traffic_generator_gmii_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc <= '1;
    end else if (init) begin
      crc <= '1;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/traffic_generator_gmii_scheduler.sv
// GMII frame sequencer: preamble+SFD, frame bytes replayed from the buffer RAM, then idle gap.
// Define TRAFFIC_GENERATOR_GMII_FCS_EN to append a generated CRC-32 FCS after the data.
module traffic_generator_gmii_scheduler
  import traffic_generator_gmii_pkg::*;
#(
  parameter int C_FRAME_BUF_ADDRESS_WIDTH = 9,
  parameter int C_MIN_IFG                 = 12
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 enable,
  input  logic [31:0]                          interframe_gap,
  input  logic [31:0]                          interburst_gap,
  input  logic [31:0]                          frames_per_burst,
  input  logic [63:0]                          total_frames,
  input  logic [15:0]                          frame_size,
  output logic [C_FRAME_BUF_ADDRESS_WIDTH-1:0] buf_rd_addr,
  input  logic [31:0]                          buf_rd_data,
  output logic [7:0]                           gmii_txd,
  output logic                                 gmii_tx_en,
  output logic                                 gmii_tx_er,
  output logic [63:0]                          pkts,
  output logic                                 busy
);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] size_l;
  logic [31:0] ifg_l, ibg_l, fpb_l;
  logic [31:0] burst_cnt, gap_cnt, gap_len;
  logic [63:0] sent;
  logic [23:0] hold;
  logic        enable_q;

  logic        gap_over, finished, start_frame, emit_data, frame_end, pkt_done;
  logic [7:0]  data_byte;

  function automatic logic [31:0] clamp_gap(input logic [31:0] g);
    return (g < 32'(C_MIN_IFG)) ? 32'(C_MIN_IFG) : g;
  endfunction

  assign gap_over    = (state == ST_GAP) && (gap_cnt == gap_len);
  assign finished    = (total_frames != 64'd0) && (sent == total_frames);
  assign start_frame = enable && (frame_size != 16'd0) &&
                       ((state == ST_IDLE) || (gap_over && !finished));
  assign emit_data   = (state == ST_DATA) && (cnt != size_l);
  // Lane 0 comes straight from the RAM; lanes 1..3 from the word captured with lane 0.
  assign data_byte   = (cnt[1:0] == 2'd0) ? buf_rd_data[31:24] : hold[23:16];

`ifdef TRAFFIC_GENERATOR_GMII_FCS_EN
  logic [31:0] crc, fcs_shift;
  logic [1:0]  fcs_sel;
  logic [7:0]  fcs_byte;

  traffic_generator_gmii_crc32 u_crc32 (
    .clk    (clk),
    .resetn (resetn),
    .init   (start_frame),
    .en     (emit_data),
    .data   (data_byte),
    .crc    (crc)
  );

  assign fcs_sel   = (state == ST_FCS) ? cnt[1:0] : 2'd0;
  assign fcs_shift = (~crc) >> {fcs_sel, 3'b000};
  assign fcs_byte  = fcs_shift[7:0];
  assign frame_end = (state == ST_FCS) && (cnt == 16'd4);
  assign pkt_done  = (state == ST_FCS) && (cnt == 16'd3);
`else
  assign frame_end = (state == ST_DATA) && (cnt == size_l);
  assign pkt_done  = emit_data && (cnt == size_l - 16'd1);
`endif

  assign gmii_tx_er = 1'b0;
  assign busy       = (state != ST_IDLE) && (state != ST_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      gmii_txd    <= '0;
      gmii_tx_en  <= 1'b0;
      buf_rd_addr <= '0;
      pkts        <= '0;
      enable_q    <= 1'b0;
      cnt         <= '0;
      size_l      <= '0;
      ifg_l       <= '0;
      ibg_l       <= '0;
      fpb_l       <= '0;
      burst_cnt   <= '0;
      gap_cnt     <= '0;
      gap_len     <= '0;
      sent        <= '0;
      hold        <= '0;
    end else begin
      enable_q <= enable;
      if (enable && !enable_q) pkts <= '0;
      else if (pkt_done)       pkts <= pkts + 64'd1;

      if (start_frame) begin
        size_l      <= frame_size;
        ifg_l       <= interframe_gap;
        ibg_l       <= interburst_gap;
        fpb_l       <= frames_per_burst;
        buf_rd_addr <= '0;
        cnt         <= 16'd1;
        gmii_txd    <= PREAMBLE_BYTE;
        gmii_tx_en  <= 1'b1;
        state       <= ST_PREAMBLE;
      end else if (frame_end) begin
        gmii_txd   <= '0;
        gmii_tx_en <= 1'b0;
        gap_cnt    <= 32'd1;
        sent       <= sent + 64'd1;
        state      <= ST_GAP;
        if ((fpb_l != 32'd0) && (burst_cnt + 32'd1 == fpb_l)) begin
          gap_len   <= clamp_gap(ibg_l);
          burst_cnt <= '0;
        end else begin
          gap_len   <= clamp_gap(ifg_l);
          burst_cnt <= burst_cnt + 32'd1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (!enable) begin
              sent      <= '0;
              burst_cnt <= '0;
            end
          end
          ST_PREAMBLE: begin
            if (cnt == 16'(PREAMBLE_LEN - 1)) begin
              gmii_txd <= SFD_BYTE;
              cnt      <= '0;
              state    <= ST_DATA;
            end else begin
              gmii_txd <= PREAMBLE_BYTE;
              cnt      <= cnt + 16'd1;
            end
          end
          ST_DATA: begin
            if (emit_data) begin
              gmii_txd <= data_byte;
              cnt      <= cnt + 16'd1;
              if (cnt[1:0] == 2'd0) begin
                hold        <= buf_rd_data[23:0];
                buf_rd_addr <= buf_rd_addr + C_FRAME_BUF_ADDRESS_WIDTH'(1);
              end else begin
                hold <= {hold[15:0], 8'h00};
              end
            end
`ifdef TRAFFIC_GENERATOR_GMII_FCS_EN
            else begin
              gmii_txd <= fcs_byte;
              cnt      <= 16'd1;
              state    <= ST_FCS;
            end
          end
          ST_FCS: begin
            gmii_txd <= fcs_byte;
            cnt      <= cnt + 16'd1;
`endif
          end
          ST_GAP: begin
            if (gap_over) begin
              state <= finished ? ST_DONE : ST_IDLE;
              if (!finished && !enable) begin
                sent      <= '0;
                burst_cnt <= '0;
              end
            end else begin
              gap_cnt <= gap_cnt + 32'd1;
            end
          end
          ST_DONE: begin
            if (!enable) begin
              state     <= ST_IDLE;
              sent      <= '0;
              burst_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_generator_gmii_scheduler.sv
// Directed bench for traffic_generator_gmii_scheduler; FCS cases run when
// TRAFFIC_GENERATOR_GMII_FCS_EN is defined.
module tb_traffic_generator_gmii_scheduler;

`ifdef TRAFFIC_GENERATOR_GMII_FCS_EN
  localparam int FCS_LEN = 4;
`else
  localparam int FCS_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [31:0] ifg, ibg, fpb;
  logic [63:0] total;
  logic [15:0] size;
  logic [8:0]  addr;
  logic [31:0] rd_data;
  logic [7:0]  txd;
  logic        tx_en, tx_er;
  logic [63:0] pkts;
  logic        busy;

  logic [31:0] mem [0:511];

  int checks = 0;
  int passes = 0;

  int          frame_lens[$];
  int          gap_lens[$];
  logic [7:0]  bytes[$];
  int          run;
  bit          prev_en, seen, er_seen;

  traffic_generator_gmii_scheduler #(
    .C_FRAME_BUF_ADDRESS_WIDTH (9),
    .C_MIN_IFG                 (12)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .enable           (enable),
    .interframe_gap   (ifg),
    .interburst_gap   (ibg),
    .frames_per_burst (fpb),
    .total_frames     (total),
    .frame_size       (size),
    .buf_rd_addr      (addr),
    .buf_rd_data      (rd_data),
    .gmii_txd         (txd),
    .gmii_tx_en       (tx_en),
    .gmii_tx_er       (tx_er),
    .pkts             (pkts),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[addr];

  task automatic mon_clear();
    frame_lens.delete();
    gap_lens.delete();
    bytes.delete();
    run = 0;
    prev_en = 1'b0;
    seen = 1'b0;
  endtask

  // Advance to the next falling edge and record the line activity.
  task automatic step();
    @(negedge clk);
    if (tx_er !== 1'b0) er_seen = 1'b1;
    if (tx_en) begin
      if (!prev_en) begin
        if (seen) gap_lens.push_back(run);
        run = 0;
      end
      run++;
      bytes.push_back(txd);
    end else begin
      if (prev_en) begin
        frame_lens.push_back(run);
        run = 0;
        seen = 1'b1;
      end
      run++;
    end
    prev_en = tx_en;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frame_lens.size() < n && k < budget) begin step(); k++; end
    if (frame_lens.size() < n) begin
      checks++;
      $display("FAIL wait_frames: got %0d frames, expected %0d", frame_lens.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin step(); k++; end
    if (busy) begin
      checks++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, budget);
    end
  endtask

  task automatic go_idle();
    enable = 1'b0;
    wait_idle(600);
    repeat (3) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0;
    ifg = 0; ibg = 0; fpb = 0; total = 0; size = 0;
    er_seen = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mon_clear();
    repeat (3) @(negedge clk);
    checks++; if (txd !== 8'h00) $display("FAIL reset_txd: got %0h, expected 0", txd); else passes++;
    checks++; if (tx_en !== 1'b0) $display("FAIL reset_tx_en: got %0b, expected 0", tx_en); else passes++;
    checks++; if (tx_er !== 1'b0) $display("FAIL reset_tx_er: got %0b, expected 0", tx_er); else passes++;
    checks++; if (addr !== 9'd0) $display("FAIL reset_addr: got %0h, expected 0", addr); else passes++;
    checks++; if (pkts !== 64'd0) $display("FAIL reset_pkts: got %0d, expected 0", pkts); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b, expected 0", busy); else passes++;
    resetn = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_basic();
    mon_clear();
    size = 16'd64; ifg = 12; ibg = 0; fpb = 0; total = 3;
    enable = 1'b1;
    wait_frames(3, 1000);
    wait_idle(100);
    checks++; if (frame_lens.size() !== 3) $display("FAIL basic_nframes: got %0d, expected 3", frame_lens.size()); else passes++;
    for (int i = 0; i < 3 && i < frame_lens.size(); i++) begin
      checks++;
      if (frame_lens[i] !== 72 + FCS_LEN) $display("FAIL basic_len%0d: got %0d, expected %0d", i, frame_lens[i], 72 + FCS_LEN);
      else passes++;
    end
    for (int i = 0; i < 2 && i < gap_lens.size(); i++) begin
      checks++;
      if (gap_lens[i] !== 12) $display("FAIL basic_gap%0d: got %0d, expected 12", i, gap_lens[i]);
      else passes++;
    end
    checks++; if (run !== 13) $display("FAIL basic_final_gap: got %0d idle samples at DONE, expected 13", run); else passes++;
    checks++; if (pkts !== 64'd3) $display("FAIL basic_pkts: got %0d, expected 3", pkts); else passes++;
    repeat (30) step();
    checks++; if (frame_lens.size() !== 3) $display("FAIL basic_done_holds: got %0d frames, expected 3", frame_lens.size()); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_done_busy: got %0b, expected 0", busy); else passes++;
    go_idle();
  endtask

  task automatic test_data_order();
    logic [7:0] exp_b [14];
    for (int i = 0; i < 7; i++) exp_b[i] = 8'h55;
    exp_b[7] = 8'hD5;
    exp_b[8] = 8'h00; exp_b[9] = 8'h11; exp_b[10] = 8'h22;
    exp_b[11] = 8'h33; exp_b[12] = 8'h44; exp_b[13] = 8'h55;
    mem[0] = 32'h00112233; mem[1] = 32'h44556677;
    mon_clear();
    size = 16'd6; ifg = 12; total = 1; fpb = 0;
    enable = 1'b1;
    wait_frames(1, 200);
    wait_idle(100);
    checks++;
    if (frame_lens.size() < 1 || frame_lens[0] !== 14 + FCS_LEN)
      $display("FAIL order_len: got %0d, expected %0d", (frame_lens.size() > 0) ? frame_lens[0] : -1, 14 + FCS_LEN);
    else passes++;
    for (int i = 0; i < 14 && i < bytes.size(); i++) begin
      checks++;
      if (bytes[i] !== exp_b[i]) $display("FAIL order_byte%0d: got %0h, expected %0h", i, bytes[i], exp_b[i]);
      else passes++;
    end
    mem[0] = 32'h0; mem[1] = 32'h0;
    go_idle();
  endtask

  task automatic test_burst();
    int exp_g [4] = '{20, 100, 20, 100};
    mon_clear();
    size = 16'd8; ifg = 20; ibg = 100; fpb = 2; total = 5;
    enable = 1'b1;
    wait_frames(5, 2000);
    wait_idle(200);
    checks++; if (gap_lens.size() !== 4) $display("FAIL burst_ngaps: got %0d, expected 4", gap_lens.size()); else passes++;
    for (int i = 0; i < 4 && i < gap_lens.size(); i++) begin
      checks++;
      if (gap_lens[i] !== exp_g[i]) $display("FAIL burst_gap%0d: got %0d, expected %0d", i, gap_lens[i], exp_g[i]);
      else passes++;
    end
    checks++; if (pkts !== 64'd5) $display("FAIL burst_pkts: got %0d, expected 5", pkts); else passes++;
    checks++; if (er_seen !== 1'b0) $display("FAIL tx_er_seen: got %0b, expected 0", er_seen); else passes++;
    go_idle();
  endtask

  task automatic test_min_ifg();
    mon_clear();
    size = 16'd8; ifg = 3; ibg = 0; fpb = 0; total = 2;
    enable = 1'b1;
    wait_frames(2, 400);
    wait_idle(100);
    checks++;
    if (gap_lens.size() < 1 || gap_lens[0] !== 12)
      $display("FAIL min_ifg_gap: got %0d, expected 12", (gap_lens.size() > 0) ? gap_lens[0] : -1);
    else passes++;
    checks++; if (pkts !== 64'd2) $display("FAIL min_ifg_pkts: got %0d, expected 2", pkts); else passes++;
    go_idle();
  endtask

  task automatic test_zero_size();
    mon_clear();
    size = 16'd0; ifg = 12; total = 0; fpb = 0;
    enable = 1'b1;
    repeat (20) step();
    checks++; if (frame_lens.size() !== 0 || tx_en !== 1'b0) $display("FAIL zero_size_tx: got %0d frames, tx_en %0b, expected none", frame_lens.size(), tx_en); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL zero_size_busy: got %0b, expected 0", busy); else passes++;
    go_idle();
  endtask

  task automatic test_disable_mid_frame();
    int k = 0;
    mon_clear();
    size = 16'd64; ifg = 12; total = 0; fpb = 0;
    enable = 1'b1;
    wait_frames(3, 1000);
    while (!tx_en && k < 100) begin step(); k++; end
    repeat (20) step();
    enable = 1'b0;
    wait_idle(300);
    repeat (30) step();
    checks++; if (frame_lens.size() !== 4) $display("FAIL disable_nframes: got %0d, expected 4", frame_lens.size()); else passes++;
    checks++;
    if (frame_lens.size() < 4 || frame_lens[3] !== 72 + FCS_LEN)
      $display("FAIL disable_len4: got %0d, expected %0d", (frame_lens.size() > 3) ? frame_lens[3] : -1, 72 + FCS_LEN);
    else passes++;
    checks++; if (pkts !== 64'd4) $display("FAIL disable_pkts: got %0d, expected 4", pkts); else passes++;
    enable = 1'b1;
    step();
    checks++; if (pkts !== 64'd0) $display("FAIL reenable_pkts: got %0d, expected 0", pkts); else passes++;
    checks++; if (tx_en !== 1'b1 || txd !== 8'h55) $display("FAIL reenable_preamble: got en=%0b txd=%0h, expected en=1 txd=55", tx_en, txd); else passes++;
    go_idle();
  endtask

`ifdef TRAFFIC_GENERATOR_GMII_FCS_EN
  function automatic logic [31:0] ref_fcs(input int n);
    logic [31:0] c, w, r;
    logic [7:0]  b, rb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      w = mem[i / 4];
      b = w[31 - 8 * (i % 4) -: 8];
      for (int k = 0; k < 8; k++) rb[k] = b[7-k];
      c = c ^ {rb, 24'h000000};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return ~r;
  endfunction

  task automatic test_fcs();
    logic [31:0] exp_fcs;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    exp_fcs = ref_fcs(60);
    mon_clear();
    size = 16'd60; ifg = 12; total = 1; fpb = 0;
    enable = 1'b1;
    wait_frames(1, 300);
    wait_idle(100);
    checks++;
    if (frame_lens.size() < 1 || frame_lens[0] !== 72)
      $display("FAIL fcs_len: got %0d, expected 72", (frame_lens.size() > 0) ? frame_lens[0] : -1);
    else passes++;
    for (int i = 0; i < 4 && 68 + i < bytes.size(); i++) begin
      checks++;
      if (bytes[68+i] !== exp_fcs[8*i +: 8]) $display("FAIL fcs_byte%0d: got %0h, expected %0h", i, bytes[68+i], exp_fcs[8*i +: 8]);
      else passes++;
    end
    go_idle();
  endtask
`endif

  task automatic test_async_reset();
    int k = 0;
    mon_clear();
    size = 16'd64; ifg = 12; total = 0; fpb = 0;
    enable = 1'b1;
    wait_frames(1, 300);
    while (!tx_en && k < 100) begin step(); k++; end
    repeat (15) step();
    #2 resetn = 1'b0;
    #1;
    checks++; if (tx_en !== 1'b0) $display("FAIL areset_tx_en: got %0b, expected 0", tx_en); else passes++;
    checks++; if (txd !== 8'h00) $display("FAIL areset_txd: got %0h, expected 0", txd); else passes++;
    checks++; if (pkts !== 64'd0) $display("FAIL areset_pkts: got %0d, expected 0", pkts); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL areset_busy: got %0b, expected 0", busy); else passes++;
    checks++; if (addr !== 9'd0) $display("FAIL areset_addr: got %0h, expected 0", addr); else passes++;
    enable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) step();
    checks++; if (tx_en !== 1'b0) $display("FAIL areset_after: got tx_en %0b, expected 0", tx_en); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_data_order();
    test_burst();
    test_min_ifg();
    test_zero_size();
    test_disable_mid_frame();
`ifdef TRAFFIC_GENERATOR_GMII_FCS_EN
    test_fcs();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
